hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised hazard, forwarding and debug-run controller for the five-stage pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB latches. It generates forwarding selects for the EX ALU operands, load-use stalls, taken-branch flushes and halt/single-step control, and it keeps stall and flush performance counters. It supersedes the free-running latch behaviour of the current pipeline top.

## Interface
- W, 5: register address width
- CNT_W, 16: performance counter width
- DRAIN, 3: bubble cycles needed to empty ID/EX..MEM/WB after fetch stops
- FWD_EN, 1: 0 forces both forwarding selects to 00
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- rs_IFID, rt_IFID  in  W  source registers of the instruction in IF/ID
- rs_IDEX, rt_IDEX  in  W  source registers of the instruction in ID/EX
- reg_dest_addr_IDEX  in  W  destination register; m_MemRead_IDEX  in  1
- reg_dest_addr_EXMEM  in  W;  wb_RegWrite_EXMEM  in  1
- reg_dest_addr_MEMWB  in  W;  wb_RegWrite_MEMWB  in  1
- pcSrc_MEM  in  1  branch taken, resolved in MEM
- dbg_halt_req, dbg_step, dbg_resume  in  1  single-cycle debug pulses
- fwd_a_EX, fwd_b_EX  out  2  operand select: 00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB write-back data
- pc_write, ifid_write  out  1  PC and IF/ID load enables
- idex_bubble  out  1  zero the ID/EX control fields on the next edge
- flush_IFID, flush_IDEX, flush_EXMEM  out  1  clear the latch on the next edge
- halted  out  1  pipeline is empty and stopped
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Forwarding for operand A (operand B is the same with rt):
  - Select 10 when wb_RegWrite_EXMEM is 1, reg_dest_addr_EXMEM is not 0, and reg_dest_addr_EXMEM equals rs_IDEX.
  - Otherwise select 01 under the same conditions using the MEM/WB fields.
  - Otherwise select 00.
  - EX/MEM always has priority over MEM/WB.
- Load-use hazard:
  - Occurs when m_MemRead_IDEX is 1, reg_dest_addr_IDEX is not 0, and it equals rs_IFID or rt_IFID.
  - Response: pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle. stall_cnt increments.
- Taken branch (pcSrc_MEM=1):
  - flush_IFID, flush_IDEX and flush_EXMEM are all 1, and pc_write=1. flush_cnt increments.
  - The branch overrides a simultaneous load-use stall. The stall is then not counted.
- Debug FSM states:
  - RUN: normal operation.
  - DRAIN:
    - pc_write=0, ifid_write=0, idex_bubble=1.
    - A DRAIN-cycle counter runs; when it reaches DRAIN-1 the FSM moves to HALTED.
    - If pcSrc_MEM fires during DRAIN: pc_write=1 for that cycle only (PC takes the branch target), the flushes apply, and the counter restarts.
  - HALTED: halted=1, pc_write=0, ifid_write=0, idex_bubble=1.
  - STEP: pc_write=1 and ifid_write=1 for one cycle, then DRAIN.
- Debug FSM transitions:
  - RUN → DRAIN on dbg_halt_req.
  - HALTED → STEP on dbg_step.
  - HALTED or DRAIN → RUN on dbg_resume.
  - If dbg_resume and dbg_step arrive together, dbg_resume wins.
  - dbg_halt_req in a non-RUN state is ignored.
- Counters saturate at all-ones and never wrap. Stall cycles forced by DRAIN or HALTED are not counted.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the FSM state, and they take effect on the next clk edge.
- The load-use stall lasts one cycle. In the following cycle the load sits in EX/MEM and the dependent instruction gets fwd select 01 one stage later.
- Branch flush latency is 0 cycles: wrong-path instructions are cleared on the same edge on which PC loads the target.
- halted asserts DRAIN cycles after the dbg_halt_req edge if no branch occurs during DRAIN.
- A step executes exactly one instruction. halted reasserts DRAIN+1 cycles after dbg_step.
- Reset values (all asynchronous, active-low):
  - FSM = RUN, drain counter = 0, stall_cnt = 0, flush_cnt = 0, halted = 0.
  - Combinational outputs take their RUN values: pc_write=1, ifid_write=1, everything else 0.
- Reset asserted mid-DRAIN or mid-STEP returns the FSM to RUN with no residual stall.

## Structure
- Shared package `pipeline_pkg`:
  - fwd select constants FWD_RF=2'b00, FWD_EXMEM=2'b10, FWD_MEMWB=2'b01
  - the debug state encoding
  - W
- Sub-module `forward_unit`: purely combinational, instantiated once, providing the A and B selects. Everything else stays in hazard_ctrl.

## Test plan
- add $3,$1,$2 then sub $4,$3,$5 back-to-back → fwd_a_EX=10 in the sub's EX cycle; for the instruction after next that reads $3, fwd_a_EX=01.
- lw $2,0($1) then add $4,$2,$3 → exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; then fwd_a_EX=01; stall_cnt=1.
- pcSrc_MEM=1 in the same cycle as a load-use hazard → three flushes and pc_write=1, no stall, flush_cnt=1, stall_cnt unchanged.
- dbg_halt_req → halted=1 after 3 cycles; dbg_step → one instruction enters IF/ID, halted=1 again after 4 cycles; dbg_resume → RUN with pc_write=1.
- Writes to $0 in EX/MEM and MEM/WB → fwd selects stay 00; lw to $0 → no stall.
- Force stall_cnt to 16'hFFFF and trigger another stall → stays 16'hFFFF. Drop reset low mid-DRAIN → FSM in RUN, counters 0, halted 0 with no clock edge needed.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: forwarding select codes, debug FSM encoding, register address width.
package pipeline_pkg;

  localparam int W = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic [1:0] ST_STEP   = 2'd3;

endpackage

// File: rtl/hazard_ctrl_forward_unit.sv
// Combinational EX operand forwarding selects; EX/MEM result beats MEM/WB write-back data.
module forward_unit
  import pipeline_pkg::*;
#(
  parameter int W      = pipeline_pkg::W,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [W-1:0] rs_IDEX,
  input  logic [W-1:0] rt_IDEX,
  input  logic [W-1:0] reg_dest_addr_EXMEM,
  input  logic         wb_RegWrite_EXMEM,
  input  logic [W-1:0] reg_dest_addr_MEMWB,
  input  logic         wb_RegWrite_MEMWB,
  output logic [1:0]   fwd_a_EX,
  output logic [1:0]   fwd_b_EX
);

  function automatic logic [1:0] select(input logic [W-1:0] src);
    logic exmem_hit;
    logic memwb_hit;
    exmem_hit = wb_RegWrite_EXMEM && (reg_dest_addr_EXMEM != '0) && (reg_dest_addr_EXMEM == src);
    memwb_hit = wb_RegWrite_MEMWB && (reg_dest_addr_MEMWB != '0) && (reg_dest_addr_MEMWB == src);
    if (!FWD_EN)        return FWD_RF;
    else if (exmem_hit) return FWD_EXMEM;
    else if (memwb_hit) return FWD_MEMWB;
    else                return FWD_RF;
  endfunction

  always_comb begin
    fwd_a_EX = select(rs_IDEX);
    fwd_b_EX = select(rt_IDEX);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and debug halt/step controller for the five-stage pipeline,
// with saturating stall and flush event counters.
module hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int W      = pipeline_pkg::W,
  parameter int CNT_W  = 16,
  parameter int DRAIN  = 3,
  parameter bit FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     rs_IFID,
  input  logic [W-1:0]     rt_IFID,
  input  logic [W-1:0]     rs_IDEX,
  input  logic [W-1:0]     rt_IDEX,
  input  logic [W-1:0]     reg_dest_addr_IDEX,
  input  logic             m_MemRead_IDEX,
  input  logic [W-1:0]     reg_dest_addr_EXMEM,
  input  logic             wb_RegWrite_EXMEM,
  input  logic [W-1:0]     reg_dest_addr_MEMWB,
  input  logic             wb_RegWrite_MEMWB,
  input  logic             pcSrc_MEM,
  input  logic             dbg_halt_req,
  input  logic             dbg_step,
  input  logic             dbg_resume,
  output logic [1:0]       fwd_a_EX,
  output logic [1:0]       fwd_b_EX,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_EXMEM,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int DC_W = (DRAIN > 1) ? $clog2(DRAIN) : 1;
  localparam logic [DC_W-1:0] DRAIN_LAST = DC_W'(DRAIN - 1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [DC_W-1:0] drain_cnt;
  logic [DC_W-1:0] drain_cnt_nxt;
  logic            load_use;
  logic            stall_ev;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  forward_unit #(.W(W), .FWD_EN(FWD_EN)) u_fwd (
    .rs_IDEX             (rs_IDEX),
    .rt_IDEX             (rt_IDEX),
    .reg_dest_addr_EXMEM (reg_dest_addr_EXMEM),
    .wb_RegWrite_EXMEM   (wb_RegWrite_EXMEM),
    .reg_dest_addr_MEMWB (reg_dest_addr_MEMWB),
    .wb_RegWrite_MEMWB   (wb_RegWrite_MEMWB),
    .fwd_a_EX            (fwd_a_EX),
    .fwd_b_EX            (fwd_b_EX)
  );

  assign load_use = m_MemRead_IDEX && (reg_dest_addr_IDEX != '0) &&
                    ((reg_dest_addr_IDEX == rs_IFID) || (reg_dest_addr_IDEX == rt_IFID));

  // A taken branch always clears the wrong path, whatever the debug state.
  assign flush_IFID  = pcSrc_MEM;
  assign flush_IDEX  = pcSrc_MEM;
  assign flush_EXMEM = pcSrc_MEM;
  assign halted      = (state == ST_HALTED);

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    stall_ev    = 1'b0;
    case (state)
      ST_RUN: begin
        if (!pcSrc_MEM && load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          stall_ev    = 1'b1;
        end
      end
      ST_DRAIN: begin
        pc_write    = pcSrc_MEM;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      ST_HALTED: begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      default: begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      ST_RUN: begin
        if (dbg_halt_req) begin
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = '0;
        end
      end
      ST_DRAIN: begin
        if (dbg_resume) begin
          state_nxt     = ST_RUN;
          drain_cnt_nxt = '0;
        end else if (pcSrc_MEM) begin
          drain_cnt_nxt = '0;
        end else if (drain_cnt == DRAIN_LAST) begin
          state_nxt     = ST_HALTED;
          drain_cnt_nxt = '0;
        end else begin
          drain_cnt_nxt = drain_cnt + DC_W'(1);
        end
      end
      ST_HALTED: begin
        if (dbg_resume)    state_nxt = ST_RUN;
        else if (dbg_step) state_nxt = ST_STEP;
      end
      default: begin
        state_nxt     = ST_DRAIN;
        drain_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (stall_ev)  stall_cnt <= sat_inc(stall_cnt);
      if (pcSrc_MEM) flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected control outputs are queued with each stimulus row
// and popped when the row's combinational outputs settle.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  rs_IFID = '0, rt_IFID = '0, rs_IDEX = '0, rt_IDEX = '0, reg_dest_addr_IDEX = '0;
  logic        m_MemRead_IDEX = 1'b0;
  logic [4:0]  reg_dest_addr_EXMEM = '0, reg_dest_addr_MEMWB = '0;
  logic        wb_RegWrite_EXMEM = 1'b0, wb_RegWrite_MEMWB = 1'b0;
  logic        pcSrc_MEM = 1'b0, dbg_halt_req = 1'b0, dbg_step = 1'b0, dbg_resume = 1'b0;
  logic [1:0]  fwd_a_EX, fwd_b_EX, s_fwd_a, s_fwd_b;
  logic        pc_write, ifid_write, idex_bubble, flush_IFID, flush_IDEX, flush_EXMEM, halted;
  logic        s_pc_write, s_ifid_write, s_idex_bubble, s_flush_IFID, s_flush_IDEX, s_flush_EXMEM, s_halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  typedef struct packed {
    logic [4:0] rs_ifid, rt_ifid, rs_idex, rt_idex, dst_idex;
    logic       memrd;
    logic [4:0] dst_exmem;
    logic       rw_exmem;
    logic [4:0] dst_memwb;
    logic       rw_memwb;
    logic       pcsrc, halt, step, resume;
  } stim_t;

  localparam stim_t IDLE = '0;

  stim_t       stim_q[$];
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .rs_IFID(rs_IFID), .rt_IFID(rt_IFID), .rs_IDEX(rs_IDEX), .rt_IDEX(rt_IDEX),
    .reg_dest_addr_IDEX(reg_dest_addr_IDEX), .m_MemRead_IDEX(m_MemRead_IDEX),
    .reg_dest_addr_EXMEM(reg_dest_addr_EXMEM), .wb_RegWrite_EXMEM(wb_RegWrite_EXMEM),
    .reg_dest_addr_MEMWB(reg_dest_addr_MEMWB), .wb_RegWrite_MEMWB(wb_RegWrite_MEMWB),
    .pcSrc_MEM(pcSrc_MEM), .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step), .dbg_resume(dbg_resume),
    .fwd_a_EX(fwd_a_EX), .fwd_b_EX(fwd_b_EX), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .flush_EXMEM(flush_EXMEM), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance on the same stimulus, so saturation is reachable in a few cycles.
  hazard_ctrl #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .rs_IFID(rs_IFID), .rt_IFID(rt_IFID), .rs_IDEX(rs_IDEX), .rt_IDEX(rt_IDEX),
    .reg_dest_addr_IDEX(reg_dest_addr_IDEX), .m_MemRead_IDEX(m_MemRead_IDEX),
    .reg_dest_addr_EXMEM(reg_dest_addr_EXMEM), .wb_RegWrite_EXMEM(wb_RegWrite_EXMEM),
    .reg_dest_addr_MEMWB(reg_dest_addr_MEMWB), .wb_RegWrite_MEMWB(wb_RegWrite_MEMWB),
    .pcSrc_MEM(pcSrc_MEM), .dbg_halt_req(dbg_halt_req), .dbg_step(dbg_step), .dbg_resume(dbg_resume),
    .fwd_a_EX(s_fwd_a), .fwd_b_EX(s_fwd_b), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .idex_bubble(s_idex_bubble), .flush_IFID(s_flush_IFID), .flush_IDEX(s_flush_IDEX),
    .flush_EXMEM(s_flush_EXMEM), .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  wire [10:0] obs = {fwd_a_EX, fwd_b_EX, pc_write, ifid_write, idex_bubble,
                     flush_IFID, flush_IDEX, flush_EXMEM, halted};

  function automatic logic [10:0] ob(input logic [1:0] fa, input logic [1:0] fb, input logic pw,
                                     input logic iw, input logic bub, input logic [2:0] fl, input logic h);
    return {fa, fb, pw, iw, bub, fl, h};
  endfunction

  localparam logic [10:0] O_RUN   = {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0};
  localparam logic [10:0] O_STALL = {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0};
  localparam logic [10:0] O_HALT  = {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1};
  localparam logic [10:0] O_BR    = {2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0};

  task automatic drive(input stim_t s);
    @(negedge clk);
    rs_IFID = s.rs_ifid;  rt_IFID = s.rt_ifid;  rs_IDEX = s.rs_idex;  rt_IDEX = s.rt_idex;
    reg_dest_addr_IDEX = s.dst_idex;  m_MemRead_IDEX = s.memrd;
    reg_dest_addr_EXMEM = s.dst_exmem;  wb_RegWrite_EXMEM = s.rw_exmem;
    reg_dest_addr_MEMWB = s.dst_memwb;  wb_RegWrite_MEMWB = s.rw_memwb;
    pcSrc_MEM = s.pcsrc;  dbg_halt_req = s.halt;  dbg_step = s.step;  dbg_resume = s.resume;
    #2;
  endtask

  task automatic push(input stim_t s, input logic [10:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs, O_RUN); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_forwarding();
    stim_t s;
    logic [10:0] e;
    s = IDLE; s.rs_idex = 3; s.rt_idex = 5; s.dst_exmem = 3; s.rw_exmem = 1;
    push(s, ob(2'b10, 2'b00, 1, 1, 0, 3'b000, 0));
    s = IDLE; s.rs_idex = 3; s.rt_idex = 7; s.dst_exmem = 4; s.rw_exmem = 1; s.dst_memwb = 3; s.rw_memwb = 1;
    push(s, ob(2'b01, 2'b00, 1, 1, 0, 3'b000, 0));
    s = IDLE; s.rs_idex = 3; s.rt_idex = 3; s.dst_exmem = 3; s.rw_exmem = 1; s.dst_memwb = 3; s.rw_memwb = 1;
    push(s, ob(2'b10, 2'b10, 1, 1, 0, 3'b000, 0));
    s = IDLE; s.rs_idex = 1; s.rt_idex = 9; s.dst_exmem = 1; s.rw_exmem = 0; s.dst_memwb = 9; s.rw_memwb = 1;
    push(s, ob(2'b00, 2'b01, 1, 1, 0, 3'b000, 0));
    s = IDLE; s.rs_idex = 8; s.rt_idex = 8; s.dst_exmem = 8; s.rw_exmem = 1;
    push(s, ob(2'b10, 2'b10, 1, 1, 0, 3'b000, 0));
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL forward[%0d] got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_zero_reg();
    stim_t s;
    logic [10:0] e;
    s = IDLE; s.dst_exmem = 0; s.rw_exmem = 1; s.dst_memwb = 0; s.rw_memwb = 1;
    push(s, O_RUN);
    s = IDLE; s.memrd = 1; s.dst_idex = 0; s.rs_ifid = 0; s.rt_ifid = 0;
    push(s, O_RUN);
    push(IDLE, O_RUN);
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL zero_reg[%0d] got=%b want=%b", i, obs, e); end
    end
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL zero_reg_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_load_use();
    stim_t s;
    logic [10:0] e;
    s = IDLE; s.rs_ifid = 2; s.rt_ifid = 3; s.memrd = 1; s.dst_idex = 2; s.rs_idex = 1;
    push(s, O_STALL);
    s = IDLE; s.rs_ifid = 2; s.rt_ifid = 3; s.dst_exmem = 2; s.rw_exmem = 1;
    push(s, O_RUN);
    s = IDLE; s.rs_idex = 2; s.rt_idex = 3; s.dst_memwb = 2; s.rw_memwb = 1;
    push(s, ob(2'b01, 2'b00, 1, 1, 0, 3'b000, 0));
    s = IDLE; s.rs_ifid = 4; s.rt_ifid = 7; s.memrd = 1; s.dst_idex = 7;
    push(s, O_STALL);
    push(IDLE, O_RUN);
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs, e); end
    end
    exp_stall += 2;
    checks++;
    if (stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL load_use_stall_cnt got=%0d want=%0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_branch_override();
    stim_t s;
    logic [10:0] e;
    s = IDLE; s.rs_ifid = 2; s.memrd = 1; s.dst_idex = 2; s.pcsrc = 1;
    push(s, O_BR);
    push(IDLE, O_RUN);
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL branch[%0d] got=%b want=%b", i, obs, e); end
    end
    exp_flush += 1;
    checks++;
    if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL branch_counters got=%0d/%0d want=%0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
  endtask

  task automatic test_debug();
    stim_t s;
    logic [10:0] e;
    s = IDLE; s.halt = 1;   push(s, O_RUN);
    push(IDLE, O_STALL);
    s = IDLE; s.rs_ifid = 2; s.memrd = 1; s.dst_idex = 2; push(s, O_STALL);
    push(IDLE, O_STALL);
    s = IDLE; s.halt = 1;   push(s, O_HALT);
    s = IDLE; s.step = 1;   push(s, O_HALT);
    push(IDLE, O_RUN);
    for (int k = 0; k < 3; k++) push(IDLE, O_STALL);
    push(IDLE, O_HALT);
    s = IDLE; s.step = 1; s.resume = 1; push(s, O_HALT);
    push(IDLE, O_RUN);
    s = IDLE; s.halt = 1;   push(s, O_RUN);
    push(IDLE, O_STALL);
    s = IDLE; s.pcsrc = 1;  push(s, ob(2'b00, 2'b00, 1, 0, 1, 3'b111, 0));
    for (int k = 0; k < 3; k++) push(IDLE, O_STALL);
    push(IDLE, O_HALT);
    s = IDLE; s.resume = 1; push(s, O_HALT);
    push(IDLE, O_RUN);
    s = IDLE; s.halt = 1;   push(s, O_RUN);
    push(IDLE, O_STALL);
    s = IDLE; s.resume = 1; push(s, O_STALL);
    push(IDLE, O_RUN);
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin errors++; $display("FAIL debug[%0d] got=%b want=%b", i, obs, e); end
    end
    exp_flush += 1;
    checks++;
    if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin
      errors++; $display("FAIL debug_counters got=%0d/%0d want=%0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall);
    end
  endtask

  task automatic test_reset_mid_drain();
    stim_t s;
    s = IDLE; s.halt = 1;
    drive(s);
    drive(IDLE);
    checks++;
    if (obs !== O_STALL) begin errors++; $display("FAIL pre_reset_drain got=%b want=%b", obs, O_STALL); end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (obs !== O_RUN) begin errors++; $display("FAIL async_reset_outputs got=%b want=%b", obs, O_RUN); end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin
      errors++; $display("FAIL async_reset_counters got=%0d/%0d/%0d want=0/0/0", stall_cnt, flush_cnt, s_stall_cnt);
    end
    exp_stall = 0;
    exp_flush = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_back_to_back_saturation();
    stim_t s;
    logic [10:0] e;
    int want_sat;
    s = IDLE; s.rs_ifid = 5; s.memrd = 1; s.dst_idex = 5;
    for (int k = 0; k < 20; k++) push(s, O_STALL);
    for (int i = 0; stim_q.size() > 0; i++) begin
      drive(stim_q.pop_front());
      e = exp_q.pop_front();
      want_sat = (i > 15) ? 15 : i;
      checks++;
      if (obs !== e || stall_cnt !== 16'(i) || s_stall_cnt !== 4'(want_sat)) begin
        errors++;
        $display("FAIL stall_run[%0d] got=%b/%0d/%0d want=%b/%0d/%0d", i, obs, stall_cnt, s_stall_cnt, e, i, want_sat);
      end
    end
    drive(IDLE);
    checks++;
    if (s_stall_cnt !== 4'hF || stall_cnt !== 16'd20) begin
      errors++; $display("FAIL stall_saturate got=%0d/%0d want=15/20", s_stall_cnt, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_zero_reg();
    test_load_use();
    test_branch_override();
    test_debug();
    test_reset_mid_drain();
    test_back_to_back_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
